// File: rtl/heu_param.sv
// heu_param: histogram-equalisation unit for one ROWS x COLS greyscale frame,
// with a per-frame bypass / full-equalise / clip-limited-equalise mode.
module heu_param #(
    parameter int ROWS       = 5,
    parameter int COLS       = 80,
    parameter int PIX_W      = 8,
    parameter int CLIP_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ipgu_out_ready,
    input  logic             rdn_in_ready,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] d [ROWS][COLS],
    output logic             in_ready,
    output logic             out_ready,
    output logic [PIX_W-1:0] q [ROWS][COLS],
    output logic [2:0]       o_dbg_state
);
    localparam int BINS = 2**PIX_W;
    localparam int N    = ROWS * COLS;
    localparam int CW   = $clog2(N + 1);
    localparam int NW   = CW + PIX_W;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW   = $clog2(CW + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HIST = 3'd1;
    localparam logic [2:0] S_CDF  = 3'd2;
    localparam logic [2:0] S_LUT  = 3'd3;
    localparam logic [2:0] S_MAP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       r_state;
    logic             r_clip;
    logic             r_out_ready;
    logic [PIX_W-1:0] r_frame [ROWS][COLS];
    logic [PIX_W-1:0] r_q     [ROWS][COLS];
    logic [CW-1:0]    r_hist  [BINS];
    logic [CW-1:0]    r_cdf   [BINS];
    logic [PIX_W-1:0] r_lut   [BINS];
    logic [RW-1:0]    r_row;
    logic [CLW-1:0]   r_col;
    logic [PIX_W-1:0] r_bin;
    logic [SW-1:0]    r_step;
    logic [CW-1:0]    r_acc;
    logic [CW-1:0]    r_total;
    logic [CW-1:0]    r_cdf_min;
    logic             r_min_found;
    logic [NW-1:0]    r_rem;
    logic [NW-1:0]    r_dsh;
    logic [PIX_W-1:0] r_quo;

    logic [PIX_W-1:0] w_pix;
    logic [CW-1:0]    w_hist_cur;
    logic [CW-1:0]    w_acc_next;
    logic [NW-1:0]    w_diff;
    logic [NW-1:0]    w_num;
    logic [CW-1:0]    w_den;
    logic             w_ge;
    logic [PIX_W-1:0] w_quo_next;
    logic [PIX_W-1:0] w_lut_val;
    logic             w_last_bin;
    logic             w_row_last;
    logic             w_col_last;

    assign in_ready    = (r_state == S_IDLE);
    assign out_ready   = r_out_ready;
    assign q           = r_q;
    assign o_dbg_state = r_state;

    assign w_pix      = r_frame[r_row][r_col];
    assign w_hist_cur = r_hist[w_pix];
    assign w_acc_next = r_acc + r_hist[r_bin];
    assign w_diff     = NW'(r_cdf[r_bin] - r_cdf_min);
    assign w_num      = (w_diff << PIX_W) - w_diff;   // (cdf - cdf_min) * (BINS-1)
    assign w_den      = r_total - r_cdf_min;
    assign w_ge       = (r_rem >= r_dsh);
    assign w_quo_next = (r_quo << 1) | PIX_W'(w_ge);
    assign w_last_bin = (r_bin == PIX_W'(BINS - 1));
    assign w_row_last = (r_row == RW'(ROWS - 1));
    assign w_col_last = (r_col == CLW'(COLS - 1));

    // Single-level frames map identically; empty leading bins are never indexed.
    always_comb begin
        w_lut_val = w_quo_next;
        if (r_total == r_cdf_min)
            w_lut_val = r_bin;
        else if (r_cdf[r_bin] == '0)
            w_lut_val = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clip      <= 1'b0;
            r_out_ready <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_bin       <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_total     <= '0;
            r_cdf_min   <= '0;
            r_min_found <= 1'b0;
            r_rem       <= '0;
            r_dsh       <= '0;
            r_quo       <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_frame[r][c] <= '0;
                    r_q[r][c]     <= '0;
                end
            end
            for (int b = 0; b < BINS; b++) begin
                r_hist[b] <= '0;
                r_cdf[b]  <= '0;
                r_lut[b]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ipgu_out_ready) begin
                        r_frame     <= d;
                        r_clip      <= (mode == 2'd2);
                        r_row       <= '0;
                        r_col       <= '0;
                        r_bin       <= '0;
                        r_step      <= '0;
                        r_acc       <= '0;
                        r_cdf_min   <= '0;
                        r_min_found <= 1'b0;
                        for (int b = 0; b < BINS; b++) r_hist[b] <= '0;
                        if (mode == 2'd0) begin
                            r_q     <= d;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_HIST;
                        end
                    end
                end
                S_HIST: begin
                    // Clip mode drops the excess above CLIP_LIMIT rather than redistributing it.
                    if (!r_clip || (w_hist_cur < CW'(CLIP_LIMIT)))
                        r_hist[w_pix] <= w_hist_cur + CW'(1);
                    if (w_col_last) begin
                        r_col <= '0;
                        if (w_row_last) begin
                            r_row   <= '0;
                            r_state <= S_CDF;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end else begin
                        r_col <= r_col + CLW'(1);
                    end
                end
                S_CDF: begin
                    r_cdf[r_bin] <= w_acc_next;
                    r_acc        <= w_acc_next;
                    if (!r_min_found && (w_acc_next != '0)) begin
                        r_min_found <= 1'b1;
                        r_cdf_min   <= w_acc_next;
                    end
                    r_bin <= r_bin + PIX_W'(1);
                    if (w_last_bin) begin
                        r_total <= w_acc_next;
                        r_state <= S_LUT;
                    end
                end
                S_LUT: begin
                    // Quotient never exceeds BINS-1, so CW shift-subtract steps suffice.
                    if (r_step == '0) begin
                        r_rem  <= w_num;
                        r_dsh  <= NW'(w_den) << (CW - 1);
                        r_quo  <= '0;
                        r_step <= SW'(1);
                    end else begin
                        if (w_ge) r_rem <= r_rem - r_dsh;
                        r_dsh <= r_dsh >> 1;
                        r_quo <= w_quo_next;
                        if (r_step == SW'(CW)) begin
                            r_lut[r_bin] <= w_lut_val;
                            r_step       <= '0;
                            r_bin        <= r_bin + PIX_W'(1);
                            if (w_last_bin) begin
                                r_row   <= '0;
                                r_state <= S_MAP;
                            end
                        end else begin
                            r_step <= r_step + SW'(1);
                        end
                    end
                end
                S_MAP: begin
                    for (int c = 0; c < COLS; c++)
                        r_q[r_row][c] <= r_lut[r_frame[r_row][c]];
                    if (w_row_last) begin
                        r_row   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                S_DONE: begin
                    // First DONE cycle raises out_ready; the handshake is seen from then on.
                    if (!r_out_ready) begin
                        r_out_ready <= 1'b1;
                    end else if (rdn_in_ready) begin
                        r_out_ready <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_heu_param.sv
// Directed bench for heu_param: bypass, flat, two-level, clip vs full,
// back-pressure and mid-frame reset, with hand-computed expected images.
`timescale 1ns/1ps
module tb_heu_param;
    localparam int ROWS = 5;
    localparam int COLS = 80;
    localparam int EQ_LAT = 400 + 256 + 256 * 10 + 5 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ipgu_out_ready = 1'b0;
    logic       rdn_in_ready = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] d [ROWS][COLS];
    logic       in_ready;
    logic       out_ready;
    logic [7:0] q [ROWS][COLS];
    logic [2:0] dbg_state;
    logic [7:0] exp_img [ROWS][COLS];

    int n_vec = 0;
    int n_err = 0;

    heu_param #(.ROWS(ROWS), .COLS(COLS), .PIX_W(8), .CLIP_LIMIT(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ipgu_out_ready (ipgu_out_ready),
        .rdn_in_ready   (rdn_in_ready),
        .mode           (mode),
        .d              (d),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .q              (q),
        .o_dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Row-major: first n0 pixels = a, next n1 = b, remainder = c.
    task automatic fill_d(input int n0, input int n1, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) begin
                int idx;
                idx = r * COLS + k;
                d[r][k] = (idx < n0) ? a : ((idx < n0 + n1) ? b : c);
            end
    endtask

    task automatic fill_exp(input int n0, input int n1, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) begin
                int idx;
                idx = r * COLS + k;
                exp_img[r][k] = (idx < n0) ? a : ((idx < n0 + n1) ? b : c);
            end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) begin
                d[r][k]       = 8'((r * COLS + k) % 256);
                exp_img[r][k] = 8'((r * COLS + k) % 256);
            end
    endtask

    task automatic scramble_d();
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                d[r][k] = 8'($urandom_range(0, 255));
    endtask

    task automatic count_q_diff(output int n);
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                if (q[r][k] !== exp_img[r][k]) n++;
    endtask

    task automatic count_q_nonzero(output int n);
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                if (q[r][k] !== 8'd0) n++;
    endtask

    // Presents the frame for one edge (T0), then disturbs d and mode.
    task automatic start_frame(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        ipgu_out_ready = 1'b1;
        @(posedge clk);
        #1;
        ipgu_out_ready = 1'b0;
        mode = 2'($urandom_range(0, 3));
        scramble_d();
    endtask

    // Edges after T0 until out_ready is seen; 0 means the budget expired.
    task automatic wait_out_ready(output int lat);
        lat = 0;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk);
            #1;
            if (out_ready === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_release();
        @(negedge clk);
        rdn_in_ready = 1'b1;
        @(posedge clk);
        #1;
        rdn_in_ready = 1'b0;
    endtask

    task automatic test_reset();
        int nz;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_vec++; if (out_ready !== 1'b0) begin n_err++; $display("FAIL reset_out_ready: got %b expected 0", out_ready); end
        count_q_nonzero(nz);
        n_vec++; if (nz != 0) begin n_err++; $display("FAIL reset_q: %0d nonzero pixels, expected 0", nz); end
        n_vec++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        int lat, nd;
        fill_ramp();
        start_frame(2'd0);
        wait_out_ready(lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL bypass_latency: got %0d expected 1", lat); end
        count_q_diff(nd);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL bypass_q: %0d pixels differ, expected 0", nd); end
        do_release();
        n_vec++; if (out_ready !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bypass_release: out_ready %b in_ready %b, expected 0 1", out_ready, in_ready); end
    endtask

    task automatic test_flat();
        int lat, nd;
        fill_d(400, 0, 8'h37, 8'h37, 8'h37);
        fill_exp(400, 0, 8'h37, 8'h37, 8'h37);
        rdn_in_ready = 1'b1;
        start_frame(2'd1);
        wait_out_ready(lat);
        n_vec++; if (lat != EQ_LAT) begin n_err++; $display("FAIL flat_latency: got %0d expected %0d", lat, EQ_LAT); end
        count_q_diff(nd);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL flat_q: %0d pixels differ, expected 0", nd); end
        @(posedge clk);
        #1;
        n_vec++; if (out_ready !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flat_one_cycle_done: out_ready %b in_ready %b, expected 0 1", out_ready, in_ready); end
        rdn_in_ready = 1'b0;
    endtask

    task automatic test_two_level();
        int lat, nd;
        fill_d(200, 200, 8'h10, 8'h80, 8'h80);
        fill_exp(200, 200, 8'h00, 8'hFF, 8'hFF);
        start_frame(2'd1);
        wait_out_ready(lat);
        n_vec++; if (lat != EQ_LAT) begin n_err++; $display("FAIL two_level_latency: got %0d expected %0d", lat, EQ_LAT); end
        count_q_diff(nd);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL two_level_q: %0d pixels differ, expected 0", nd); end
        do_release();
    endtask

    task automatic test_clip_vs_full();
        int lat, nd;
        // mode 1: 0x40 -> 76500/350 = 218
        fill_d(50, 300, 8'h00, 8'h40, 8'hFF);
        fill_exp(50, 300, 8'd0, 8'd218, 8'd255);
        start_frame(2'd1);
        wait_out_ready(lat);
        n_vec++; if (lat != EQ_LAT) begin n_err++; $display("FAIL full_latency: got %0d expected %0d", lat, EQ_LAT); end
        count_q_diff(nd);
        n_vec++; if (nd != 0 || q[2][0] !== 8'd218) begin n_err++; $display("FAIL full_q: %0d pixels differ, q[2][0]=%0d expected 218", nd, q[2][0]); end
        do_release();
        // mode 2: 0x40 clipped to 64 -> 16320/114 = 143
        fill_d(50, 300, 8'h00, 8'h40, 8'hFF);
        fill_exp(50, 300, 8'd0, 8'd143, 8'd255);
        start_frame(2'd2);
        wait_out_ready(lat);
        count_q_diff(nd);
        n_vec++; if (nd != 0 || q[2][0] !== 8'd143) begin n_err++; $display("FAIL clip_q: %0d pixels differ, q[2][0]=%0d expected 143", nd, q[2][0]); end
        do_release();
        // mode 3 behaves like mode 1
        fill_d(50, 300, 8'h00, 8'h40, 8'hFF);
        fill_exp(50, 300, 8'd0, 8'd218, 8'd255);
        start_frame(2'd3);
        wait_out_ready(lat);
        count_q_diff(nd);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL mode3_q: %0d pixels differ, expected 0", nd); end
        do_release();
    endtask

    task automatic test_back_pressure();
        int lat, nd, bad_or, bad_ir, bad_q;
        fill_ramp();
        start_frame(2'd0);
        wait_out_ready(lat);
        bad_or = 0; bad_ir = 0; bad_q = 0;
        for (int i = 0; i < 20; i++) begin
            ipgu_out_ready = (i == 10);
            @(posedge clk);
            #1;
            if (out_ready !== 1'b1) bad_or++;
            if (in_ready !== 1'b0) bad_ir++;
            count_q_diff(nd);
            if (nd != 0) bad_q++;
        end
        ipgu_out_ready = 1'b0;
        n_vec++; if (bad_or != 0) begin n_err++; $display("FAIL bp_out_ready_held: %0d cycles low, expected 0", bad_or); end
        n_vec++; if (bad_ir != 0) begin n_err++; $display("FAIL bp_in_ready_low: %0d cycles high, expected 0", bad_ir); end
        n_vec++; if (bad_q != 0) begin n_err++; $display("FAIL bp_q_stable: %0d cycles changed, expected 0", bad_q); end
        do_release();
        n_vec++; if (out_ready !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: out_ready %b in_ready %b, expected 0 1", out_ready, in_ready); end
        @(posedge clk);
        #1;
        count_q_diff(nd);
        n_vec++; if (in_ready !== 1'b1 || nd != 0) begin n_err++; $display("FAIL bp_pulse_ignored: in_ready %b, %0d pixels differ, expected 1 0", in_ready, nd); end
    endtask

    task automatic test_reset_mid();
        int lat, nd, nz;
        fill_d(200, 200, 8'h10, 8'h80, 8'h80);
        start_frame(2'd1);
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        count_q_nonzero(nz);
        n_vec++; if (out_ready !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_flags: out_ready %b in_ready %b, expected 0 1", out_ready, in_ready); end
        n_vec++; if (nz != 0) begin n_err++; $display("FAIL midreset_q: %0d nonzero pixels, expected 0", nz); end
        @(negedge clk);
        rst_n = 1'b1;
        fill_d(200, 200, 8'h10, 8'h80, 8'h80);
        fill_exp(200, 200, 8'h00, 8'hFF, 8'hFF);
        start_frame(2'd1);
        wait_out_ready(lat);
        n_vec++; if (lat != EQ_LAT) begin n_err++; $display("FAIL rerun_latency: got %0d expected %0d", lat, EQ_LAT); end
        count_q_diff(nd);
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL rerun_q: %0d pixels differ, expected 0", nd); end
        do_release();
    endtask

    initial begin
        fill_d(0, 0, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_bypass();
        test_flat();
        test_two_level();
        test_clip_vs_full();
        test_back_pressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
